lda_projector: RTL and testbench
================================

# lda_projector

Streaming LDA projection and classification stage. Holds the discriminant direction (w1, w2) and a decision threshold in IEEE-754 single precision. Projects each incoming 2-D sample onto that direction, d = w1·s1 + w2·s2 − thr, and emits d together with a class bit. It sits downstream of the eigenvector stage, which supplies the weights, and upstream of the result sink.

## Interface

Parameters:
- MUL_LAT, default 4: fixed latency in cycles of the fmul core. Must match the generated core.
- ADD_LAT, default 4: fixed latency in cycles of the fadd core. Must match the generated core.
- OUT_DEPTH, default 16: output FIFO depth in entries. Must be ≥ MUL_LAT + 2·ADD_LAT + 1 and a power of two.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  a weight/threshold update is offered.
- cfg_ready  out  1  the update is accepted this cycle.
- cfg_w1  in  32  float32 weight for s1.
- cfg_w2  in  32  float32 weight for s2.
- cfg_thr  in  32  float32 decision threshold.
- in_valid  in  1  a sample is offered.
- in_ready  out  1  the sample is accepted this cycle.
- in_s1  in  32  float32 sample component 1.
- in_s2  in  32  float32 sample component 2.
- out_valid  out  1  the head of the output FIFO is valid.
- out_ready  in  1  the sink accepts the head.
- out_d  out  32  float32 value w1·s1 + w2·s2 − thr.
- out_class  out  1  1 when out_d > 0; 0 otherwise, including ±0.
- busy  out  1  samples are in flight or the FIFO is non-empty.

## Operation

- Handshakes are valid/ready.
  - A transfer occurs on a cycle where both valid and ready are high.
  - Payload must be held stable while valid is high and ready is low.
- Coefficient registers w1, w2 and thr reset to 1.0 (0x3F800000), 1.0 and 0.0.
- cfg_ready = (inflight == 0). Updates therefore never change the weights mid-sample.
- When cfg_valid and in_valid are both high, cfg wins:
  - in_ready is forced low that cycle;
  - the sample is accepted on a later cycle using the new coefficients.
- Datapath, all stages free-running with no stall:
  - Stage M: two parallel fmul, p1 = w1·s1 and p2 = w2·s2.
  - Stage A1: fadd, y = p1 + p2.
  - Stage A2: fadd, d = y + (thr with bit 31 inverted).
- A valid bit travels through a shift register of length L = MUL_LAT + 2·ADD_LAT, alongside the cores.
- Completed results are written into the OUT_DEPTH-entry FIFO, storing d and class.
- class = ~d[31] & (d[30:0] != 0).
- Credit scheme:
  - inflight counts accepted samples not yet written to the FIFO.
  - in_ready = cfg_ready_blocking_off & ((inflight + fifo_count) < OUT_DEPTH).
  - The FIFO can never overflow, so the cores never need back-pressure.
- Counter updates on simultaneous events:
  - An accept and a FIFO write in the same cycle leave inflight unchanged.
  - A FIFO write and a read in the same cycle leave fifo_count unchanged.
- FIFO read/write pointers wrap modulo OUT_DEPTH.
- Special values propagate as the cores produce them (NaN, Inf); no extra handling.

## Timing

- Reset values: cfg_ready = 1, in_ready = 1, out_valid = 0, out_d = 0, out_class = 0, busy = 0. Counters and pointers reset to 0; the valid shift register is cleared.
- Reset asserted mid-operation discards all in-flight samples and FIFO contents. The core pipelines may hold garbage, but the cleared valid bits mask it.
- Latency:
  - A sample accepted in cycle t is written to the FIFO at the end of cycle t + L.
  - out_valid is high in cycle t + L + 1 when the FIFO was empty (minimum latency L + 1).
- Throughput is one sample per cycle while the sink keeps out_ready high.
- FIFO outputs are registered, and the head is shown whenever fifo_count > 0.
- busy = (inflight != 0) | (fifo_count != 0).

## Structure

- Shared package, lda_pkg:
  - FP_ONE = 32'h3F800000 and FP_ZERO;
  - function fp_neg, flips bit 31;
  - function fp_is_pos, returns the class rule.
  - The eigenvector stage uses the same package.
- fmul and fadd are the existing Coregen cores; the block instantiates them, not new RTL.
- One natural sub-module is lda_result_fifo, a synchronous FIFO of 33-bit entries with a count output.
- Credit logic, the valid shift register and the coefficient registers stay in the top module.

## Test plan

- Reset defaults, then a sample (s1, s2) = (1.0, 2.0) → out_d = 3.0 (0x40400000), class = 1, exactly L + 1 cycles after acceptance.
- Configure w1 = 1.0, w2 = 2.0 (0x40000000), thr = 5.0 (0x40A00000), then a sample (1.0, 1.0) → out_d = −2.0 (0xC0000000), class = 0. A sample (2.0, 1.5) → out_d = 0.0, class = 0.
- Drive cfg_valid while 3 samples are in flight → cfg_ready stays 0 until inflight = 0. The in-flight results use the old weights; later samples use the new weights.
- Drive cfg_valid and in_valid in the same cycle with an idle pipe → cfg accepted, in_ready = 0 that cycle, and the sample accepted the next cycle.
- Back-to-back stream of 40 samples with out_ready held 0 → exactly OUT_DEPTH samples accepted, then in_ready = 0. Release out_ready → all 40 results emerge in order, with pointers wrapping and nothing lost or duplicated.
- Assert rst with 5 samples in flight and 4 in the FIFO → busy = 0 and out_valid = 0 immediately. No stale result appears afterwards.

Source files
------------

// File: rtl/lda_pkg.sv
// rtl/lda_pkg.sv - float32 constants, helpers and result entry type shared by the LDA stages
package lda_pkg;

  localparam logic [31:0] FP_ONE  = 32'h3F800000;
  localparam logic [31:0] FP_ZERO = 32'h00000000;

  typedef struct packed {
    logic        cls;
    logic [31:0] d;
  } lda_result_t;

  function automatic logic [31:0] fp_neg(input logic [31:0] x);
    return {~x[31], x[30:0]};
  endfunction

  // Strictly positive: both signed zeros classify as 0.
  function automatic logic fp_is_pos(input logic [31:0] x);
    return ~x[31] & (x[30:0] != 31'd0);
  endfunction

endpackage

// File: rtl/lda_projector_if.sv
// rtl/lda_projector_if.sv - coefficient, sample and result handshakes of lda_projector
interface lda_projector_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_w1;
  logic [31:0] cfg_w2;
  logic [31:0] cfg_thr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_s1;
  logic [31:0] in_s2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_d;
  logic        out_class;

  modport master (
    output cfg_valid, cfg_w1, cfg_w2, cfg_thr, in_valid, in_s1, in_s2, out_ready,
    input  cfg_ready, in_ready, out_valid, out_d, out_class
  );

  modport slave (
    input  cfg_valid, cfg_w1, cfg_w2, cfg_thr, in_valid, in_s1, in_s2, out_ready,
    output cfg_ready, in_ready, out_valid, out_d, out_class
  );
endinterface

// File: rtl/fadd.sv
// rtl/fadd.sv - float32 adder core, round-to-nearest-even, subnormals flushed, fixed latency LAT
module fadd #(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s
);
  logic [31:0]       x, y, r;
  logic [31:0]       pipe [LAT];
  logic [7:0]        diff;
  logic [49:0]       mx, my;
  logic [50:0]       z, zn;
  logic [5:0]        lz;
  logic signed [9:0] e;
  logic [23:0]       man;
  logic [24:0]       mr;
  logic              g, st, rnd;

  always_comb begin
    if (a[30:0] >= b[30:0]) begin
      x = a; y = b;
    end else begin
      x = b; y = a;
    end
    diff = x[30:23] - y[30:23];
    mx   = {1'b1, x[22:0], 26'd0};
    my   = {1'b1, y[22:0], 26'd0};
    // Past 26 places the smaller operand only survives as a sticky bit.
    my   = (diff > 8'd26) ? 50'd1 : (my >> diff);
    z    = (x[31] == y[31]) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});
    lz   = 6'd0;
    for (int i = 0; i < 51; i++)
      if (z[i]) lz = 6'(50 - i);
    zn  = z << lz;
    e   = $signed({2'b0, x[30:23]}) + 10'sd1 - $signed({4'b0, lz});
    man = zn[50:27];
    g   = zn[26];
    st  = |zn[25:0];
    rnd = g & (st | man[0]);
    mr  = {1'b0, man} + {24'd0, rnd};
    if (mr[24]) begin
      man = mr[24:1]; e = e + 10'sd1;
    end else begin
      man = mr[23:0];
    end
    if (x[30:23] == 8'hFF)
      r = ((x[22:0] != 23'd0) || ((y[30:23] == 8'hFF) && (x[31] != y[31]))) ? 32'h7FC00000 : x;
    else if (y[30:23] == 8'd0)
      r = (x[30:23] == 8'd0) ? {x[31] & y[31], 31'd0} : x;
    else if (z == 51'd0)     r = 32'd0;
    else if (e >= 10'sd255)  r = {x[31], 8'hFF, 23'd0};
    else if (e <= 10'sd0)    r = {x[31], 31'd0};
    else                     r = {x[31], e[7:0], man[22:0]};
  end

  always_ff @(posedge clk) begin
    pipe[0] <= r;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign s = pipe[LAT-1];
endmodule

// File: rtl/fmul.sv
// rtl/fmul.sv - float32 multiplier core, round-to-nearest-even, subnormals flushed, fixed latency LAT
module fmul #(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p
);
  logic [31:0]       r;
  logic [31:0]       pipe [LAT];
  logic [47:0]       m;
  logic [23:0]       man;
  logic [24:0]       mr;
  logic signed [9:0] e;
  logic              s, g, st, rnd;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  always_comb begin
    s      = a[31] ^ b[31];
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = $signed({2'b0, a[30:23]}) + $signed({2'b0, b[30:23]}) - 10'sd127;
    if (m[47]) begin
      man = m[47:24]; g = m[23]; st = |m[22:0]; e = e + 10'sd1;
    end else begin
      man = m[46:23]; g = m[22]; st = |m[21:0];
    end
    rnd = g & (st | man[0]);
    mr  = {1'b0, man} + {24'd0, rnd};
    if (mr[24]) begin
      man = mr[24:1]; e = e + 10'sd1;
    end else begin
      man = mr[23:0];
    end
    if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) r = 32'h7FC00000;
    else if (a_inf | b_inf)                                  r = {s, 8'hFF, 23'd0};
    else if (a_zero | b_zero)                                r = {s, 31'd0};
    else if (e >= 10'sd255)                                  r = {s, 8'hFF, 23'd0};
    else if (e <= 10'sd0)                                    r = {s, 31'd0};
    else                                                     r = {s, e[7:0], man[22:0]};
  end

  always_ff @(posedge clk) begin
    pipe[0] <= r;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign p = pipe[LAT-1];
endmodule

// File: rtl/lda_result_fifo.sv
// rtl/lda_result_fifo.sv - show-ahead synchronous FIFO with registered head and occupancy count
module lda_result_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 33
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic          do_rd;

  assign do_rd    = rd_en & (count != '0);
  assign rd_ptr_n = rd_ptr + AW'(do_rd);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_n;
      case ({wr_en, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // A write landing on the next head slot bypasses the memory.
      rd_data <= (wr_en && (wr_ptr == rd_ptr_n)) ? wr_data : mem[rd_ptr_n];
    end
  end
endmodule

// File: rtl/lda_projector.sv
// rtl/lda_projector.sv - streaming LDA projection d = w1*s1 + w2*s2 - thr with class bit, credit-gated
module lda_projector
  import lda_pkg::*;
#(
  parameter int MUL_LAT   = 4,
  parameter int ADD_LAT   = 4,
  parameter int OUT_DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  lda_projector_if.slave io,
  output logic           busy
);
  localparam int L  = MUL_LAT + 2 * ADD_LAT;
  localparam int CW = $clog2(OUT_DEPTH) + 1;

  logic [31:0]   w1, w2, thr;
  logic [31:0]   p1, p2, y, d;
  logic [CW-1:0] inflight, fifo_count;
  logic [CW:0]   credit_sum;
  logic [L-1:0]  vld_sr;
  logic          cfg_fire, in_fire, wr_en, rd_en;
  lda_result_t   wr_entry, head;

  assign io.cfg_ready = (inflight == '0);
  assign cfg_fire     = io.cfg_valid & io.cfg_ready;
  assign credit_sum   = {1'b0, inflight} + {1'b0, fifo_count};
  // A pending update holds off samples so the pipe drains and the update lands.
  assign io.in_ready  = ~io.cfg_valid & (credit_sum < (CW+1)'(OUT_DEPTH));
  assign in_fire      = io.in_valid & io.in_ready;
  assign wr_en        = vld_sr[L-1];
  assign rd_en        = io.out_valid & io.out_ready;
  assign io.out_valid = (fifo_count != '0);
  assign io.out_d     = head.d;
  assign io.out_class = head.cls;
  assign busy         = (inflight != '0) | (fifo_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w1       <= FP_ONE;
      w2       <= FP_ONE;
      thr      <= FP_ZERO;
      vld_sr   <= '0;
      inflight <= '0;
    end else begin
      if (cfg_fire) begin
        w1  <= io.cfg_w1;
        w2  <= io.cfg_w2;
        thr <= io.cfg_thr;
      end
      vld_sr <= {vld_sr[L-2:0], in_fire};
      case ({in_fire, wr_en})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Coefficients are stable whenever anything is in flight, so thr is read live at the last add.
  fmul #(.LAT(MUL_LAT)) u_mul1 (.clk(clk), .a(w1), .b(io.in_s1), .p(p1));
  fmul #(.LAT(MUL_LAT)) u_mul2 (.clk(clk), .a(w2), .b(io.in_s2), .p(p2));
  fadd #(.LAT(ADD_LAT)) u_add1 (.clk(clk), .a(p1), .b(p2), .s(y));
  fadd #(.LAT(ADD_LAT)) u_add2 (.clk(clk), .a(y), .b(fp_neg(thr)), .s(d));

  assign wr_entry.cls = fp_is_pos(d);
  assign wr_entry.d   = d;

  lda_result_fifo #(.DEPTH(OUT_DEPTH), .W($bits(lda_result_t))) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_data (head),
    .count   (fifo_count)
  );
endmodule

// File: tb/tb_lda_projector.sv
// tb/tb_lda_projector.sv - scoreboard bench for lda_projector with directed float32 vectors
module tb_lda_projector;
  localparam logic [31:0] ONE   = 32'h3F800000;
  localparam logic [31:0] TWO   = 32'h40000000;
  localparam logic [31:0] THREE = 32'h40400000;
  localparam logic [31:0] FOUR  = 32'h40800000;
  localparam logic [31:0] FIVE  = 32'h40A00000;
  localparam logic [31:0] HALF  = 32'h3F000000;
  localparam logic [31:0] ONEP5 = 32'h3FC00000;
  localparam logic [31:0] M2    = 32'hC0000000;
  localparam logic [31:0] M3    = 32'hC0400000;
  localparam int          LAT_EXP = 4 + 2 * 4 + 1;

  typedef struct {
    logic [31:0] d;
    logic        c;
    int          at;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  lda_projector_if io ();

  lda_projector #(.MUL_LAT(4), .ADD_LAT(4), .OUT_DEPTH(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .io   (io.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] i2f(input int v);
    int          e;
    logic [22:0] f;
    e = 0;
    while ((v >> (e + 1)) != 0) e++;
    f = 23'((v - (1 << e)) << (23 - e));
    return {1'b0, 8'(127 + e), f};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic send(input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] ed,
                      input logic ec, input int lat, output int acc);
    int w;
    bit ok;
    io.in_valid = 1'b1;
    io.in_s1    = s1;
    io.in_s2    = s2;
    w  = 0;
    ok = 1'b0;
    while (!ok && w < 300) begin
      @(negedge clk);
      ok = io.in_ready;
      w++;
    end
    acc = cyc;
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready=%0d after %0d cycles, required 1", io.in_ready, w);
    end else begin
      exp_q.push_back('{d: ed, c: ec, at: (lat >= 0) ? cyc + lat : -1});
    end
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
  endtask

  task automatic do_cfg(input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] thr,
                        output int acc);
    int w;
    bit ok;
    io.cfg_valid = 1'b1;
    io.cfg_w1    = w1;
    io.cfg_w2    = w2;
    io.cfg_thr   = thr;
    w  = 0;
    ok = 1'b0;
    while (!ok && w < 300) begin
      @(negedge clk);
      ok = io.cfg_ready;
      w++;
    end
    acc = cyc;
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL cfg_timeout: cfg_ready=%0d after %0d cycles, required 1", io.cfg_ready, w);
    end
    @(posedge clk);
    #1;
    io.cfg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || busy) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    n_vec++;
    if (exp_q.size() != 0 || busy) begin
      n_bad++;
      $display("FAIL drain: %0d results outstanding busy=%0d, required 0 and 0", exp_q.size(), busy);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && io.out_valid && io.out_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out: got d=%h class=%0d, required no output", io.out_d, io.out_class);
      end else begin
        mon_e = exp_q.pop_front();
        if (io.out_d !== mon_e.d || io.out_class !== mon_e.c) begin
          n_bad++;
          $display("FAIL result: got d=%h class=%0d, required d=%h class=%0d",
                   io.out_d, io.out_class, mon_e.d, mon_e.c);
        end
        if (mon_e.at >= 0) begin
          n_vec++;
          if (cyc != mon_e.at) begin
            n_bad++;
            $display("FAIL latency: result in cycle %0d, required cycle %0d", cyc, mon_e.at);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required self-termination");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc3, acc_cnt;
    rst          = 1'b1;
    io.cfg_valid = 1'b0;
    io.cfg_w1    = '0;
    io.cfg_w2    = '0;
    io.cfg_thr   = '0;
    io.in_valid  = 1'b0;
    io.in_s1     = '0;
    io.in_s2     = '0;
    io.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cfg_ready", io.cfg_ready, 1);
    chk("rst_in_ready", io.in_ready, 1);
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_out_d", io.out_d, 0);
    chk("rst_out_class", io.out_class, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", io.in_ready, 1);
    @(posedge clk);
    #1;
    io.out_ready = 1'b1;

    // default weights: 1*1 + 1*2 - 0
    send(ONE, TWO, THREE, 1'b1, LAT_EXP, acc);
    wait_idle();

    do_cfg(ONE, TWO, FIVE, acc);
    send(ONE, ONE, M2, 1'b0, -1, acc);
    send(TWO, ONEP5, 32'h0, 1'b0, -1, acc);
    wait_idle();

    // update requested behind three in-flight samples
    send(FOUR, TWO, THREE, 1'b1, -1, acc);
    send(ONE, HALF, M3, 1'b0, -1, acc);
    send(TWO, TWO, ONE, 1'b1, -1, acc3);
    io.cfg_valid = 1'b1;
    io.cfg_w1    = TWO;
    io.cfg_w2    = ONE;
    io.cfg_thr   = ONE;
    @(negedge clk);
    chk("cfg_blocked_ready", io.cfg_ready, 0);
    chk("cfg_blocked_in_ready", io.in_ready, 0);
    do_cfg(TWO, ONE, ONE, acc);
    chk("cfg_accept_cycle", acc, acc3 + LAT_EXP);
    send(ONE, ONE, TWO, 1'b1, -1, acc);
    send(HALF, M3, M3, 1'b0, -1, acc);
    wait_idle();

    // cfg and sample offered together on an idle pipe
    io.cfg_valid = 1'b1;
    io.cfg_w1    = ONE;
    io.cfg_w2    = ONE;
    io.cfg_thr   = 32'h0;
    io.in_valid  = 1'b1;
    io.in_s1     = TWO;
    io.in_s2     = ONE;
    @(negedge clk);
    chk("both_cfg_ready", io.cfg_ready, 1);
    chk("both_in_ready", io.in_ready, 0);
    @(posedge clk);
    #1;
    io.cfg_valid = 1'b0;
    @(negedge clk);
    chk("both_in_ready_next", io.in_ready, 1);
    exp_q.push_back('{d: THREE, c: 1'b1, at: -1});
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    wait_idle();

    // 40-sample stream against a stalled sink
    io.out_ready = 1'b0;
    for (int k = 1; k <= 16; k++) send(i2f(k), i2f(k), i2f(2 * k), 1'b1, -1, acc);
    io.in_valid = 1'b1;
    io.in_s1    = i2f(17);
    io.in_s2    = i2f(17);
    acc_cnt = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (io.in_ready) acc_cnt++;
    end
    chk("stall_extra_accepts", 32'(acc_cnt), 0);
    chk("stall_out_valid", io.out_valid, 1);
    chk("stall_head", io.out_d, i2f(2));
    chk("stall_busy", busy, 1);
    @(posedge clk);
    #1;
    io.out_ready = 1'b1;
    for (int k = 17; k <= 40; k++) send(i2f(k), i2f(k), i2f(2 * k), 1'b1, -1, acc);
    wait_idle();

    // reset with 4 results queued and 5 in flight
    io.out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send(i2f(k), i2f(k), i2f(2 * k), 1'b1, -1, acc);
    repeat (14) @(posedge clk);
    #1;
    for (int k = 5; k <= 9; k++) send(i2f(k), i2f(k), i2f(2 * k), 1'b1, -1, acc);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", io.out_valid, 0);
    chk("midrst_cfg_ready", io.cfg_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    io.out_ready = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_out_valid", io.out_valid, 0);
    chk("post_rst_busy", busy, 0);
    @(posedge clk);
    #1;
    send(ONE, TWO, THREE, 1'b1, LAT_EXP, acc);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
